// File: rtl/gemvarray_serial_collector.sv
// Per-row LSB-first serial deserializers feeding one round-robin arbitrated output register.
// Each row holds at most one finished word; a word that finishes while that slot is still occupied is dropped and flagged.
module gemvarray_serial_collector #(
   parameter  int ROW_CNT    = 32,
   parameter  int DATA_WIDTH = 16,
   localparam int ID_WIDTH   = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic                  serialIn      [ROW_CNT],
   input  logic                  serialInValid [ROW_CNT],
   output logic [DATA_WIDTH-1:0] outData,
   output logic [ID_WIDTH-1:0]   outRowId,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [ROW_CNT-1:0]    overflow
);

   localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int IDX_WIDTH = ID_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [ID_WIDTH-1:0]  LAST_ROW = ID_WIDTH'(ROW_CNT - 1);
   localparam logic [IDX_WIDTH-1:0] ROW_LIM  = IDX_WIDTH'(ROW_CNT);

   logic [DATA_WIDTH-1:0] shiftReg [ROW_CNT];
   logic [DATA_WIDTH-1:0] hold     [ROW_CNT];
   logic [CNT_WIDTH-1:0]  bitCnt   [ROW_CNT];
   logic [ROW_CNT-1:0]    full;
   logic [ROW_CNT-1:0]    loadMask;
   logic [ID_WIDTH-1:0]   rrPtr;
   logic [ID_WIDTH-1:0]   selRow;
   logic [IDX_WIDTH-1:0]  idx;
   logic                  selFound;
   logic                  doLoad;

   // Round-robin search starting at rrPtr, wrapping past the last row.
   always_comb begin
      selFound = 1'b0;
      selRow   = '0;
      idx      = '0;
      for (int i = 0; i < ROW_CNT; i++) begin
         idx = {1'b0, rrPtr} + IDX_WIDTH'(i);
         if (idx >= ROW_LIM) idx = idx - ROW_LIM;
         if (!selFound && full[idx[ID_WIDTH-1:0]]) begin
            selFound = 1'b1;
            selRow   = idx[ID_WIDTH-1:0];
         end
      end
      doLoad   = selFound && (!outValid || outReady);
      loadMask = '0;
      if (doLoad) loadMask[selRow] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < ROW_CNT; r++) begin
            shiftReg[r] <= '0;
            hold[r]     <= '0;
            bitCnt[r]   <= '0;
         end
         full     <= '0;
         overflow <= '0;
         rrPtr    <= '0;
         outData  <= '0;
         outRowId <= '0;
         outValid <= 1'b0;
      end else if (clear) begin
         for (int r = 0; r < ROW_CNT; r++) begin
            shiftReg[r] <= '0;
            hold[r]     <= '0;
            bitCnt[r]   <= '0;
         end
         full     <= '0;
         overflow <= '0;
         rrPtr    <= '0;
         outData  <= '0;
         outRowId <= '0;
         outValid <= 1'b0;
      end else begin
         for (int r = 0; r < ROW_CNT; r++) begin
            // A slot released by this edge's load may be refilled on the same edge.
            if (loadMask[r]) full[r] <= 1'b0;
            if (serialInValid[r]) begin
               shiftReg[r] <= {serialIn[r], shiftReg[r][DATA_WIDTH-1:1]};
               if (bitCnt[r] == LAST_BIT) begin
                  bitCnt[r] <= '0;
                  if (full[r] && !loadMask[r]) begin
                     overflow[r] <= 1'b1;
                  end else begin
                     hold[r] <= {serialIn[r], shiftReg[r][DATA_WIDTH-1:1]};
                     full[r] <= 1'b1;
                  end
               end else begin
                  bitCnt[r] <= bitCnt[r] + 1'b1;
               end
            end
         end
         if (doLoad) begin
            outData  <= hold[selRow];
            outRowId <= selRow;
            outValid <= 1'b1;
            rrPtr    <= (selRow == LAST_ROW) ? '0 : selRow + 1'b1;
         end else if (outReady) begin
            outValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gemvarray_serial_collector.sv
// Bench for gemvarray_serial_collector (4 rows, 8-bit words): directed cases plus random traffic,
// all checked cycle by cycle against a word-level reference model.
module tb_gemvarray_serial_collector;

   localparam int ROWS = 4;
   localparam int DW   = 8;

   logic          clk;
   logic          rstn;
   logic          clear;
   logic          serialIn      [ROWS];
   logic          serialInValid [ROWS];
   logic [DW-1:0] outData;
   logic [1:0]    outRowId;
   logic          outValid;
   logic          outReady;
   logic [ROWS-1:0] overflow;

   int total = 0;
   int bad   = 0;

   gemvarray_serial_collector #(.ROW_CNT(ROWS), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rstn(rstn), .clear(clear),
      .serialIn(serialIn), .serialInValid(serialInValid),
      .outData(outData), .outRowId(outRowId), .outValid(outValid),
      .outReady(outReady), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per row a bit count and an accumulated value, one holding slot, and the output register.
   int            mCnt  [ROWS];
   logic [DW-1:0] mAcc  [ROWS];
   logic [DW-1:0] mHold [ROWS];
   bit            mFull [ROWS];
   logic [ROWS-1:0] mOvf;
   logic [DW-1:0] mOutData;
   int            mOutRow;
   bit            mOutValid;
   int            mPtr;

   bit  logOn = 0;
   int  seenRows[$];

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int r = 0; r < ROWS; r++) begin
         mCnt[r] = 0; mAcc[r] = '0; mHold[r] = '0; mFull[r] = 0;
      end
      mOvf = '0; mOutData = '0; mOutRow = 0; mOutValid = 0; mPtr = 0;
   endtask

   task automatic modelStep();
      bit ld;
      int sel;
      int cand;
      logic [DW-1:0] w;
      if (clear) begin
         modelReset();
         return;
      end
      ld = 0; sel = 0; w = '0;
      if (!mOutValid || outReady) begin
         for (int k = 0; k < ROWS; k++) begin
            cand = (mPtr + k) % ROWS;
            if (!ld && mFull[cand]) begin ld = 1; sel = cand; end
         end
      end
      if (ld) begin
         w = mHold[sel];
         mFull[sel] = 0;
      end
      for (int r = 0; r < ROWS; r++) begin
         if (serialInValid[r]) begin
            mAcc[r] = mAcc[r] | (DW'(serialIn[r]) << mCnt[r]);
            mCnt[r]++;
            if (mCnt[r] == DW) begin
               if (mFull[r]) mOvf[r] = 1'b1;
               else begin mHold[r] = mAcc[r]; mFull[r] = 1; end
               mAcc[r] = '0;
               mCnt[r] = 0;
            end
         end
      end
      if (ld) begin
         mOutValid = 1; mOutData = w; mOutRow = sel; mPtr = (sel + 1) % ROWS;
      end else if (outReady) begin
         mOutValid = 0;
      end
   endtask

   task automatic compareAll();
      checkVal("outValid", 32'(outValid), 32'(mOutValid));
      checkVal("outData",  32'(outData),  32'(mOutData));
      checkVal("outRowId", 32'(outRowId), 32'(mOutRow));
      checkVal("overflow", 32'(overflow), 32'(mOvf));
   endtask

   task automatic stepCycle(input logic [3:0] bits, input logic [3:0] vlds, input logic rdy, input logic clr);
      for (int r = 0; r < ROWS; r++) begin
         serialIn[r]      = bits[r];
         serialInValid[r] = vlds[r];
      end
      outReady = rdy;
      clear    = clr;
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
      if (logOn && outValid) seenRows.push_back(int'(outRowId));
   endtask

   task automatic doReset();
      for (int r = 0; r < ROWS; r++) begin
         serialIn[r] = 1'b0; serialInValid[r] = 1'b0;
      end
      clear = 1'b0; outReady = 1'b0;
      rstn = 1'b0;
      modelReset();
      #2;
      compareAll();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Streams one word per selected row, LSB first; gap inserts an idle cycle between bits.
   task automatic sendRows(input logic [31:0] words, input logic [3:0] rows, input logic rdy, input bit gap);
      logic [3:0] bits;
      for (int b = 0; b < DW; b++) begin
         for (int r = 0; r < ROWS; r++) bits[r] = words[r*DW + b];
         stepCycle(bits, rows, rdy, 1'b0);
         if (gap && b < DW - 1) stepCycle(4'h0, 4'h0, rdy, 1'b0);
      end
   endtask

   initial begin
      rstn = 1'b0; clear = 1'b0; outReady = 1'b0;
      for (int r = 0; r < ROWS; r++) begin serialIn[r] = 1'b0; serialInValid[r] = 1'b0; end
      modelReset();

      // Single word on row 2
      doReset();
      checkVal("rst_valid", 32'(outValid), 32'h0);
      sendRows(32'h00A5_0000, 4'b0100, 1'b1, 0);
      checkVal("a5_lat_valid", 32'(outValid), 32'h0);
      stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
      checkVal("a5_valid", 32'(outValid), 32'h1);
      checkVal("a5_data",  32'(outData), 32'hA5);
      checkVal("a5_row",   32'(outRowId), 32'h2);
      stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
      checkVal("a5_drop", 32'(outValid), 32'h0);

      // All rows complete together
      doReset();
      sendRows(32'h4433_2211, 4'b1111, 1'b1, 0);
      for (int i = 0; i < ROWS; i++) begin
         stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
         checkVal("multi_row",  32'(outRowId), 32'(i));
         checkVal("multi_data", 32'(outData),  32'((i + 1) * 'h11));
      end

      // Row 1 with valid toggled every other cycle
      doReset();
      sendRows(32'h0000_3C00, 4'b0010, 1'b1, 1);
      stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
      checkVal("gap_data", 32'(outData),  32'h3C);
      checkVal("gap_row",  32'(outRowId), 32'h1);

      // Backpressure and overflow on row 0
      doReset();
      sendRows(32'h0000_0001, 4'b0001, 1'b0, 0);
      sendRows(32'h0000_0002, 4'b0001, 1'b0, 0);
      sendRows(32'h0000_0003, 4'b0001, 1'b0, 0);
      checkVal("ovf_flag",  32'(overflow), 32'h1);
      checkVal("ovf_hold",  32'(outData),  32'h01);
      stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
      checkVal("ovf_second", 32'(outData), 32'h02);
      stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
      checkVal("ovf_empty", 32'(outValid), 32'h0);

      // Reset mid-word on row 3
      doReset();
      for (int b = 0; b < 5; b++) stepCycle(4'b1000, 4'b1000, 1'b1, 1'b0);
      doReset();
      sendRows(32'hF000_0000, 4'b1000, 1'b1, 0);
      stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
      checkVal("rstmid_data", 32'(outData),  32'hF0);
      checkVal("rstmid_row",  32'(outRowId), 32'h3);
      checkVal("rstmid_ovf",  32'(overflow), 32'h0);

      // Rows 0 and 3 streaming back to back
      doReset();
      seenRows.delete();
      logOn = 1;
      for (int n = 0; n < 4; n++)
         sendRows({8'($urandom), 16'h0, 8'($urandom)}, 4'b1001, 1'b1, 0);
      stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
      stepCycle(4'h0, 4'h0, 1'b1, 1'b0);
      logOn = 0;
      checkVal("rr_count", 32'(seenRows.size()), 32'd8);
      for (int i = 0; i < seenRows.size() && i < 8; i++)
         checkVal("rr_order", 32'(seenRows[i]), (i % 2 == 0) ? 32'd0 : 32'd3);

      // Random traffic, including clears and heavy backpressure phases
      doReset();
      for (int c = 0; c < 4000; c++) begin
         logic [3:0] bits;
         logic [3:0] vlds;
         logic rdy;
         bits = 4'($urandom);
         vlds = 4'($urandom) | 4'($urandom);
         rdy  = (c % 1000 < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         stepCycle(bits, vlds, rdy, $urandom_range(0, 299) == 0);
         if (c % 1500 == 1499) doReset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gemvarray_serial_collector.md
GEMVARRAY_SERIAL_COLLECTOR -- requirements
Module: gemvarray_serial_collector

Interface
REQ-001 SHALL have parameter ROW_CNT, default 32: number of serial row streams, which equals the array PiCaSO row count.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: bits per assembled word.
REQ-003 SHALL have derived localparam ID_WIDTH = max(1, clog2(ROW_CNT)).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush of all state, same effect as reset.
REQ-007 SHALL have port serialIn, input, unpacked array [ROW_CNT] of 1 bit: per-row serial data from the tile array.
REQ-008 SHALL have port serialInValid, input, unpacked array [ROW_CNT] of 1 bit: per-row bit-valid qualifier.
REQ-009 SHALL have port outData, output, DATA_WIDTH bits: assembled word.
REQ-010 SHALL have port outRowId, output, ID_WIDTH bits: source row index of outData.
REQ-011 SHALL have port outValid, output, 1 bit: outData and outRowId are valid.
REQ-012 SHALL have port outReady, input, 1 bit: downstream accepts the word.
REQ-013 SHALL have port overflow, output, ROW_CNT bits: sticky per-row word-drop flags.

Function
REQ-014 SHALL run an independent deserializer per row: a shift register plus a bit counter (0..DATA_WIDTH-1), sampling serialIn[r] only on edges where serialInValid[r]=1.
REQ-015 SHALL assemble words LSB-first: the first valid bit lands in bit 0 and the DATA_WIDTH-th valid bit lands in bit DATA_WIDTH-1.
REQ-016 SHALL hold the bit counter and shift register unchanged while serialInValid[r]=0, so gaps mid-word are allowed.
REQ-017 On the edge sampling the DATA_WIDTH-th bit, SHALL write the complete word (including that bit) into per-row holding register hold[r], set full[r]=1, and reset the bit counter to 0.
REQ-018 SHALL treat the output stage as a single register; it loads when outValid=0 or outReady=1 and at least one full[r]=1.
REQ-019 SHALL select the source row round-robin: the first r with full[r]=1, searching from rrPtr upward and wrapping ROW_CNT-1 to 0.
REQ-020 On load, SHALL set outData=hold[r], outRowId=r, outValid=1, clear full[r], and set rrPtr=(r+1) mod ROW_CNT.
REQ-021 When outValid=1 and outReady=1 and no row is full, SHALL set outValid=0 on the next edge.
REQ-022 While outValid=1 and outReady=0, SHALL hold outData and outRowId stable.
REQ-023 SHALL have latency of 1 cycle: the word completes at edge k, outValid=1 after edge k+1 when the output register is free or being accepted.
REQ-024 When a word completes for row r at the same edge full[r] is cleared by an output load, SHALL accept the new word into hold[r] with full[r]=1 and no overflow.
REQ-025 When a word completes for row r while full[r]=1 and row r is not being loaded that edge, SHALL drop the new word, keep hold[r] unchanged, and set overflow[r]=1 (sticky).
REQ-026 SHALL allow multiple rows to complete on the same edge; each SHALL be stored independently.
REQ-027 SHALL have sustained throughput of one word per cycle while outReady=1.

Reset
REQ-028 On rstn=0, asynchronously or on clear=1 at an edge, SHALL set outValid=0, outData=0, outRowId=0, overflow=0, all full=0, all bit counters=0, all shift/hold registers=0, and rrPtr=0.
REQ-029 Reset or clear mid-word SHALL discard partial words; the next valid bit after release SHALL be bit 0.
REQ-030 clear SHALL take priority over all same-edge activity.

Verification (ROW_CNT=4, DATA_WIDTH=8)
REQ-031 SHALL cover: row 2 streams 0xA5 LSB-first on 8 consecutive valid cycles with outReady=1 -> outValid=1 one cycle after the 8th bit, outData=0xA5, outRowId=2, then outValid=0.
REQ-032 SHALL cover: rows 0..3 simultaneously stream 0x11, 0x22, 0x33, 0x44 with outReady=1 -> four consecutive output cycles in order rowId 0, 1, 2, 3 with matching data.
REQ-033 SHALL cover: row 1 sends 0x3C with valid toggled every other cycle -> outData=0x3C, outRowId=1, identical to the gapless case.
REQ-034 SHALL cover: outReady=0 while row 0 sends 0x01, then 0x02, then 0x03 -> output holds 0x01, hold[0]=0x02, 0x03 is dropped, overflow=4'b0001; with outReady=1 the outputs are 0x01 then 0x02.
REQ-035 SHALL cover: rstn pulsed low after 5 bits of row 3, then row 3 sends 0xF0 -> output 0xF0 and overflow=0.
REQ-036 SHALL cover: rrPtr fairness with rows 0 and 3 continuously full and outReady=1 -> rowIds alternate 0, 3, 0, 3.
